// File: rtl/freq_range_monitor.sv
// Samples readout every SAMPLE_PERIOD clocks, compares it against [lo_limit, hi_limit]
// and debounces the result into a GOOD/BAD alarm. Min/max tracking: FREQ_RANGE_MONITOR_MINMAX_EN.
module freq_range_monitor #(
  parameter int unsigned WIDTH         = 32,
  parameter int unsigned SAMPLE_PERIOD = 131072,
  parameter int unsigned FAIL_COUNT    = 3,
  parameter int unsigned PASS_COUNT    = 3
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             ena,
  input  logic             clr,
  input  logic [WIDTH-1:0] readout,
  input  logic [WIDTH-1:0] lo_limit,
  input  logic [WIDTH-1:0] hi_limit,
  output logic             sample_strb,
  output logic [WIDTH-1:0] last_sample,
  output logic             in_range,
  output logic             alarm,
  output logic             alarm_sticky,
  output logic [WIDTH-1:0] min_seen,
  output logic [WIDTH-1:0] max_seen
);

  localparam int unsigned TW   = $clog2(SAMPLE_PERIOD);
  localparam int unsigned CMAX = (FAIL_COUNT > PASS_COUNT) ? FAIL_COUNT : PASS_COUNT;
  localparam int unsigned CW   = $clog2(CMAX + 1);

  localparam logic [TW-1:0] TMR_LAST  = TW'(SAMPLE_PERIOD - 1);
  localparam logic [CW-1:0] FAIL_LAST = CW'(FAIL_COUNT - 1);
  localparam logic [CW-1:0] PASS_LAST = CW'(PASS_COUNT - 1);

  typedef enum logic [1:0] {
    S_DISABLED,
    S_WARMUP,
    S_GOOD,
    S_BAD
  } state_t;

  state_t        state, state_nxt;
  logic [TW-1:0] timer, timer_nxt;
  logic [CW-1:0] fail_cnt, fail_cnt_nxt;
  logic [CW-1:0] pass_cnt, pass_cnt_nxt;
  logic          tick;
  logic          sample_ok;
  logic          enter_bad;

  // An inverted window (lo > hi) can never satisfy both bounds.
  assign sample_ok = (readout >= lo_limit) && (readout <= hi_limit);
  assign tick      = ena && (state != S_DISABLED) && (timer == TMR_LAST);
  assign alarm     = (state == S_BAD);

  always_comb begin
    state_nxt    = state;
    timer_nxt    = '0;
    fail_cnt_nxt = fail_cnt;
    pass_cnt_nxt = pass_cnt;
    enter_bad    = 1'b0;
    if (!ena) begin
      state_nxt    = S_DISABLED;
      fail_cnt_nxt = '0;
      pass_cnt_nxt = '0;
    end else begin
      // Timer holds at 0 during the DISABLED->WARMUP cycle, so the first tick
      // lands SAMPLE_PERIOD cycles after the first enabled cycle.
      if (state != S_DISABLED)
        timer_nxt = (timer == TMR_LAST) ? '0 : timer + 1'b1;
      case (state)
        S_DISABLED: state_nxt = S_WARMUP;
        S_WARMUP:   if (tick) state_nxt = S_GOOD;
        S_GOOD: begin
          if (tick) begin
            if (sample_ok) begin
              fail_cnt_nxt = '0;
            end else if (fail_cnt == FAIL_LAST) begin
              fail_cnt_nxt = '0;
              state_nxt    = S_BAD;
              enter_bad    = 1'b1;
            end else begin
              fail_cnt_nxt = fail_cnt + 1'b1;
            end
          end
        end
        S_BAD: begin
          if (tick) begin
            if (!sample_ok) begin
              pass_cnt_nxt = '0;
            end else if (pass_cnt == PASS_LAST) begin
              pass_cnt_nxt = '0;
              state_nxt    = S_GOOD;
            end else begin
              pass_cnt_nxt = pass_cnt + 1'b1;
            end
          end
        end
        default: state_nxt = S_DISABLED;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state    <= S_DISABLED;
      timer    <= '0;
      fail_cnt <= '0;
      pass_cnt <= '0;
    end else begin
      state    <= state_nxt;
      timer    <= timer_nxt;
      fail_cnt <= fail_cnt_nxt;
      pass_cnt <= pass_cnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sample_strb  <= 1'b0;
      last_sample  <= '0;
      in_range     <= 1'b0;
      alarm_sticky <= 1'b0;
    end else begin
      sample_strb <= tick;
      if (tick) begin
        last_sample <= readout;
        in_range    <= sample_ok;
      end
      if (enter_bad)
        alarm_sticky <= 1'b1;
      else if (clr)
        alarm_sticky <= 1'b0;
    end
  end

`ifdef FREQ_RANGE_MONITOR_MINMAX_EN
  logic             judged;
  logic [WIDTH-1:0] min_base, max_base;

  assign judged = tick && ((state == S_GOOD) || (state == S_BAD));

  // A clr coincident with a judged tick clears first, then loads the sample.
  always_comb begin
    min_base = clr ? '1 : min_seen;
    max_base = clr ? '0 : max_seen;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      min_seen <= '1;
      max_seen <= '0;
    end else if (judged) begin
      min_seen <= (readout < min_base) ? readout : min_base;
      max_seen <= (readout > max_base) ? readout : max_base;
    end else if (clr) begin
      min_seen <= '1;
      max_seen <= '0;
    end
  end
`else
  assign min_seen = '0;
  assign max_seen = '0;
`endif

endmodule

// File: tb/tb_freq_range_monitor.sv
// Directed bench for freq_range_monitor with a tick-index/history reference model.
// Honours FREQ_RANGE_MONITOR_MINMAX_EN the same way as the design.
module tb_freq_range_monitor;

  localparam int unsigned W  = 32;
  localparam int unsigned P  = 16;
  localparam int unsigned FC = 3;
  localparam int unsigned PC = 2;

  logic         clk = 1'b0;
  logic         nrst = 1'b0;
  logic         ena = 1'b0;
  logic         clr = 1'b0;
  logic [W-1:0] readout = '0;
  logic [W-1:0] lo_limit = 1000;
  logic [W-1:0] hi_limit = 1100;
  logic         sample_strb;
  logic [W-1:0] last_sample;
  logic         in_range;
  logic         alarm;
  logic         alarm_sticky;
  logic [W-1:0] min_seen;
  logic [W-1:0] max_seen;

  int checks = 0;
  int errors = 0;

  freq_range_monitor #(
    .WIDTH(W),
    .SAMPLE_PERIOD(P),
    .FAIL_COUNT(FC),
    .PASS_COUNT(PC)
  ) dut (
    .clk(clk),
    .nrst(nrst),
    .ena(ena),
    .clr(clr),
    .readout(readout),
    .lo_limit(lo_limit),
    .hi_limit(hi_limit),
    .sample_strb(sample_strb),
    .last_sample(last_sample),
    .in_range(in_range),
    .alarm(alarm),
    .alarm_sticky(alarm_sticky),
    .min_seen(min_seen),
    .max_seen(max_seen)
  );

  always #5 clk = ~clk;

  // Reference model: ticks are every P-th enabled cycle after activation;
  // debouncing looks at the trailing run of judged results.
  logic         m_strb;
  logic [W-1:0] m_last;
  logic         m_inr;
  logic         m_bad;
  logic         m_sticky;
  logic [W-1:0] m_min;
  logic [W-1:0] m_max;
  bit           m_active;
  int           m_ecount;
  bit           m_hist[$];

  function automatic bit trailing(int n, bit v);
    if (m_hist.size() < n) return 1'b0;
    for (int i = m_hist.size() - n; i < m_hist.size(); i++)
      if (m_hist[i] != v) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_strb = 0; m_last = '0; m_inr = 0; m_bad = 0; m_sticky = 0;
`ifdef FREQ_RANGE_MONITOR_MINMAX_EN
    m_min = '1;
`else
    m_min = '0;
`endif
    m_max = '0;
    m_active = 0; m_ecount = 0;
    m_hist.delete();
  endtask

  task automatic model_step();
    bit tick;
    bit ok;
    int tn;
    tick = 0; tn = 0;
    m_strb = 0;
    if (!ena) begin
      m_active = 0; m_ecount = 0; m_bad = 0;
      m_hist.delete();
    end else if (!m_active) begin
      m_active = 1; m_ecount = 0;
    end else begin
      m_ecount++;
      if (m_ecount % P == 0) begin
        tick = 1;
        tn = m_ecount / P;
      end
    end
    if (clr) begin
      m_sticky = 0;
`ifdef FREQ_RANGE_MONITOR_MINMAX_EN
      m_min = '1;
      m_max = '0;
`endif
    end
    if (tick) begin
      ok = (readout >= lo_limit) && (readout <= hi_limit);
      m_strb = 1; m_last = readout; m_inr = ok;
      if (tn > 1) begin
`ifdef FREQ_RANGE_MONITOR_MINMAX_EN
        if (readout < m_min) m_min = readout;
        if (readout > m_max) m_max = readout;
`endif
        m_hist.push_back(ok);
        if (!m_bad && trailing(FC, 1'b0)) begin
          m_bad = 1; m_sticky = 1;
          m_hist.delete();
        end else if (m_bad && trailing(PC, 1'b1)) begin
          m_bad = 0;
          m_hist.delete();
        end
      end
    end
  endtask

  initial begin : model
    model_reset();
    forever begin
      @(posedge clk or negedge nrst);
      if (!nrst) model_reset();
      else model_step();
    end
  end

  task automatic cmp(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic pin(input string name, input logic [W-1:0] act, input logic [W-1:0] mdl,
                     input logic [W-1:0] exp);
    cmp(name, act, exp);
    cmp({name, "_model"}, mdl, exp);
  endtask

  task automatic pin_mm(input string name, input logic [W-1:0] emin, input logic [W-1:0] emax);
`ifdef FREQ_RANGE_MONITOR_MINMAX_EN
    pin({name, "_min"}, min_seen, m_min, emin);
    pin({name, "_max"}, max_seen, m_max, emax);
`else
    pin({name, "_min"}, min_seen, m_min, '0);
    pin({name, "_max"}, max_seen, m_max, '0);
`endif
  endtask

  initial begin : compare
    forever begin
      @(negedge clk);
      cmp("sample_strb", {31'd0, sample_strb}, {31'd0, m_strb});
      cmp("last_sample", last_sample, m_last);
      cmp("in_range", {31'd0, in_range}, {31'd0, m_inr});
      cmp("alarm", {31'd0, alarm}, {31'd0, m_bad});
      cmp("alarm_sticky", {31'd0, alarm_sticky}, {31'd0, m_sticky});
      cmp("min_seen", min_seen, m_min);
      cmp("max_seen", max_seen, m_max);
    end
  end

  task automatic adv(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin : stimulus
    adv(2);
    pin("rst_strb", {31'd0, sample_strb}, {31'd0, m_strb}, 0);
    pin("rst_last", last_sample, m_last, 0);
    pin("rst_alarm", {31'd0, alarm}, {31'd0, m_bad}, 0);
    pin("rst_sticky", {31'd0, alarm_sticky}, {31'd0, m_sticky}, 0);
    pin_mm("rst", '1, 0);
    nrst = 1'b1;
    adv(1);

    // Periodic sampling in range
    readout = 1050; ena = 1'b1;
    adv(16);
    pin("c16_strb", {31'd0, sample_strb}, {31'd0, m_strb}, 0);
    adv(1);
    pin("c17_strb", {31'd0, sample_strb}, {31'd0, m_strb}, 1);
    pin("c17_last", last_sample, m_last, 1050);
    pin("c17_inr", {31'd0, in_range}, {31'd0, m_inr}, 1);
    adv(1);
    pin("c18_strb", {31'd0, sample_strb}, {31'd0, m_strb}, 0);
    adv(15);
    pin("c33_strb", {31'd0, sample_strb}, {31'd0, m_strb}, 1);
    adv(16);
    pin("c49_strb", {31'd0, sample_strb}, {31'd0, m_strb}, 1);
    pin("c49_alarm", {31'd0, alarm}, {31'd0, m_bad}, 0);
    pin_mm("c49", 1050, 1050);
    ena = 1'b0;
    adv(2);

    // Out of range from tick 2: alarm after tick 4
    ena = 1'b1;
    adv(17);
    readout = 900;
    adv(16);
    pin("t2_alarm", {31'd0, alarm}, {31'd0, m_bad}, 0);
    adv(16);
    pin("t3_alarm", {31'd0, alarm}, {31'd0, m_bad}, 0);
    adv(15);
    pin("pre_t4_alarm", {31'd0, alarm}, {31'd0, m_bad}, 0);
    adv(1);
    pin("t4_alarm", {31'd0, alarm}, {31'd0, m_bad}, 1);
    pin("t4_sticky", {31'd0, alarm_sticky}, {31'd0, m_sticky}, 1);
    readout = 1050;
    adv(16);
    pin("t5_alarm", {31'd0, alarm}, {31'd0, m_bad}, 1);
    adv(16);
    pin("t6_alarm", {31'd0, alarm}, {31'd0, m_bad}, 0);
    pin("t6_sticky", {31'd0, alarm_sticky}, {31'd0, m_sticky}, 1);
    clr = 1'b1;
    adv(1);
    clr = 1'b0;
    pin("clr_sticky", {31'd0, alarm_sticky}, {31'd0, m_sticky}, 0);
    pin_mm("clr", '1, 0);
    readout = 900;
    adv(15);
    pin("p1_alarm", {31'd0, alarm}, {31'd0, m_bad}, 0);
    readout = 1050;
    adv(16);
    readout = 900;
    adv(16);
    adv(16);
    pin("p4_alarm", {31'd0, alarm}, {31'd0, m_bad}, 0);
    pin("p4_inr", {31'd0, in_range}, {31'd0, m_inr}, 0);
    pin_mm("p4", 900, 1050);
    ena = 1'b0;
    adv(2);

    // Inverted window never matches
    lo_limit = 1200; hi_limit = 1100; readout = 1150; ena = 1'b1;
    adv(17);
    pin("inv_w_inr", {31'd0, in_range}, {31'd0, m_inr}, 0);
    adv(16);
    adv(16);
    pin("inv_j2_alarm", {31'd0, alarm}, {31'd0, m_bad}, 0);
    adv(16);
    pin("inv_j3_alarm", {31'd0, alarm}, {31'd0, m_bad}, 1);
    pin("inv_j3_inr", {31'd0, in_range}, {31'd0, m_inr}, 0);

    // Disable mid-count in BAD, then re-enable: warmup leaves min/max alone
    adv(5);
    ena = 1'b0;
    adv(1);
    pin("dis_alarm", {31'd0, alarm}, {31'd0, m_bad}, 0);
    pin("dis_strb", {31'd0, sample_strb}, {31'd0, m_strb}, 0);
    adv(20);
    pin("dis_sticky", {31'd0, alarm_sticky}, {31'd0, m_sticky}, 1);
    pin("dis_last", last_sample, m_last, 1150);
    pin_mm("dis", 900, 1150);
    lo_limit = 1000; hi_limit = 1100; readout = 1234; ena = 1'b1;
    adv(17);
    pin("wu_strb", {31'd0, sample_strb}, {31'd0, m_strb}, 1);
    pin("wu_last", last_sample, m_last, 1234);
    pin_mm("wu", 900, 1150);

    // Min/max over judged samples, then clr coincident with a tick
    clr = 1'b1;
    adv(1);
    clr = 1'b0;
    pin("clr2_sticky", {31'd0, alarm_sticky}, {31'd0, m_sticky}, 0);
    readout = 1010;
    adv(15);
    readout = 1090;
    adv(16);
    readout = 1050;
    adv(16);
    pin_mm("mm3", 1010, 1090);
    adv(15);
    readout = 1070; clr = 1'b1;
    adv(1);
    clr = 1'b0;
    pin("mmclr_last", last_sample, m_last, 1070);
    pin_mm("mmclr", 1070, 1070);

    // Asynchronous reset mid-operation
    #2 nrst = 1'b0;
    #1;
    pin("arst_last", last_sample, m_last, 0);
    pin("arst_alarm", {31'd0, alarm}, {31'd0, m_bad}, 0);
    pin_mm("arst", '1, 0);
    adv(2);
    nrst = 1'b1;
    adv(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
